alu_shift_stage: RTL and testbench
==================================

ALU_SHIFT_STAGE -- requirements
Module: alu_shift_stage

Interface
REQ-001 SHALL have parameter: RD_W, default 5, destination-register tag width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port: flush  input  1  synchronous discard of all held and incoming entries.
REQ-005 SHALL have port: in_valid  input  1  upstream entry present.
REQ-006 SHALL have port: in_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port: in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 PASS.
REQ-008 SHALL have port: in_src0  input  32  value to shift.
REQ-009 SHALL have port: in_src1  input  32  shift amount; only bits [4:0] are used.
REQ-010 SHALL have port: in_rd  input  RD_W  destination tag, carried alongside the data.
REQ-011 SHALL have port: out_valid  output  1  result entry present.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port: out_result  output  32  registered shift result.
REQ-014 SHALL have port: out_rd  output  RD_W  tag of the result.
REQ-015 SHALL have port: out_zero  output  1  result equals zero; present only under SHIFT_ZERO_FLAG_EN.

Function
REQ-016 SHALL instantiate the existing barrel shifter and select its sll/srl/sra output by in_op; PASS returns in_src0 unchanged.
REQ-017 SHALL compute the result combinationally at acceptance and register it; latency 1 cycle from accept to out_valid.
REQ-018 SHALL accept an entry on a rising edge with in_valid=1 and in_ready=1, and transfer an entry on a rising edge with out_valid=1 and out_ready=1.
REQ-019 SHALL hold two entries: a main output register and a skid register; in_ready = NOT skid_valid (registered, no combinational path from out_ready).
REQ-020 SHALL load an accepted entry into the main register when main is empty or is transferring that cycle; otherwise it goes to the skid register.
REQ-021 SHALL move the skid entry into the main register on transfer, with in_ready rising the following cycle.
REQ-022 SHALL keep out_result/out_rd stable while out_valid=1 and out_ready=0.
REQ-023 SHALL force the stored result to 0 when in_rd equals 0 (x0 write), while still passing the entry through.
REQ-024 SHALL sustain one entry per cycle when out_ready is held at 1, with no bubbles.
REQ-025 SHALL preserve order: no entry overtakes an earlier one.
REQ-026 SHALL, on flush=1, clear main_valid and skid_valid at the next edge and drop any entry presented that cycle; flush overrides accept and transfer.
REQ-027 SHALL treat in_src1[31:5] as don't-care: a shift by 33 equals a shift by 1.

Reset
REQ-028 SHALL, while rst_n=0, immediately force out_valid=0, in_ready=0, main_valid=0, skid_valid=0, out_result=0, out_rd=0, out_zero=0.
REQ-029 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-030 SHALL discard any in-flight entries when reset asserts mid-transfer; none reappear after release.

Configuration
REQ-031 SHALL compile the zero flag only when SHIFT_ZERO_FLAG_EN is defined: out_zero is registered with each entry (1 if the stored result is 0) and travels through the skid register.
REQ-032 SHALL, without SHIFT_ZERO_FLAG_EN, omit the out_zero port and its storage entirely; all other behaviour is identical.

Verification
REQ-033 SHALL verify: reset, then SRA src0=0x80000000, src1=4, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=0xF8000000, out_rd=3.
REQ-034 SHALL verify: SLL 0x00000001 by src1=0x21 -> out_result=0x00000002; SRL 0x80000000 by 31 -> 0x00000001.
REQ-035 SHALL verify: three back-to-back entries with out_ready=0 -> first in main, second in skid, in_ready=0, third held upstream; out_ready=1 -> results drain in order, one per cycle.
REQ-036 SHALL verify: flush asserted with main and skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed entries never appear.
REQ-037 SHALL verify: SLL 0x12345678 by 0 with rd=0 -> out_result=0; with SHIFT_ZERO_FLAG_EN, out_zero=1; PASS 0 with rd=5 -> out_zero=1.
REQ-038 SHALL verify: rst_n pulsed low mid-stream with out_valid=1 -> out_valid drops asynchronously, stays 0 after release until a new accept.

Source files
------------

// File: rtl/alu_shift_stage.sv
// Shift ALU stage: 32-bit barrel shift feeding a two-entry (main + skid) output buffer.
// Optional zero flag enabled by defining SHIFT_ZERO_FLAG_EN.
`timescale 1ns/1ps

module alu_barrel_shifter (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_sll,
    output logic [31:0] o_srl,
    output logic [31:0] o_sra
);
    logic [31:0] w_sll [0:5];
    logic [31:0] w_srl [0:5];
    logic [31:0] w_sra [0:5];

    assign w_sll[0] = i_data;
    assign w_srl[0] = i_data;
    assign w_sra[0] = i_data;

    // Stage k shifts by 2**k when shamt bit k is set.
    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign w_sll[k+1] = i_shamt[k] ? {w_sll[k][31-SH:0], {SH{1'b0}}} : w_sll[k];
        assign w_srl[k+1] = i_shamt[k] ? {{SH{1'b0}}, w_srl[k][31:SH]} : w_srl[k];
        assign w_sra[k+1] = i_shamt[k] ? {{SH{w_sra[k][31]}}, w_sra[k][31:SH]} : w_sra[k];
    end

    assign o_sll = w_sll[5];
    assign o_srl = w_srl[5];
    assign o_sra = w_sra[5];
endmodule

module alu_shift_stage #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [31:0]     in_src0,
    input  logic [31:0]     in_src1,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [RD_W-1:0] out_rd
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    output logic            out_zero
`endif
);
    logic [31:0]     w_sll, w_srl, w_sra;
    logic [31:0]     w_shift_res, w_new_result;
    logic            w_accept, w_xfer, w_main_free;
    logic            w_skid_to_main, w_new_to_main, w_new_to_skid;
    logic            w_main_valid_nxt, w_skid_valid_nxt;
    logic            w_unused_src1_hi;

    logic            r_in_ready;
    logic            r_main_valid, r_skid_valid;
    logic [31:0]     r_main_result, r_skid_result;
    logic [RD_W-1:0] r_main_rd, r_skid_rd;

    assign w_unused_src1_hi = ^in_src1[31:5];

    alu_barrel_shifter u_shifter (
        .i_data  (in_src0),
        .i_shamt (in_src1[4:0]),
        .o_sll   (w_sll),
        .o_srl   (w_srl),
        .o_sra   (w_sra)
    );

    always_comb begin
        case (in_op)
            2'b00:   w_shift_res = w_sll;
            2'b01:   w_shift_res = w_srl;
            2'b10:   w_shift_res = w_sra;
            default: w_shift_res = in_src0;
        endcase
        // Writes to x0 still flow through so the tag stays in order downstream.
        w_new_result = (in_rd == '0) ? 32'd0 : w_shift_res;
    end

    // Main can only be empty when skid is empty, so skid never bypasses main.
    always_comb begin
        w_accept       = in_valid & r_in_ready & ~flush;
        w_xfer         = r_main_valid & out_ready;
        w_main_free    = w_xfer | ~r_main_valid;
        w_skid_to_main = w_main_free & r_skid_valid & ~flush;
        w_new_to_main  = w_main_free & ~r_skid_valid & w_accept;
        w_new_to_skid  = ~w_main_free & w_accept;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_main_free) begin
            w_main_valid_nxt = r_skid_valid | w_accept;
            w_skid_valid_nxt = 1'b0;
        end else begin
            w_main_valid_nxt = 1'b1;
            w_skid_valid_nxt = r_skid_valid | w_accept;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_result <= 32'd0;
            r_main_rd     <= '0;
            r_skid_result <= 32'd0;
            r_skid_rd     <= '0;
        end else begin
            if (w_skid_to_main) begin
                r_main_result <= r_skid_result;
                r_main_rd     <= r_skid_rd;
            end else if (w_new_to_main) begin
                r_main_result <= w_new_result;
                r_main_rd     <= in_rd;
            end
            if (w_new_to_skid) begin
                r_skid_result <= w_new_result;
                r_skid_rd     <= in_rd;
            end
        end
    end

`ifdef SHIFT_ZERO_FLAG_EN
    logic r_main_zero, r_skid_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_zero <= 1'b0;
            r_skid_zero <= 1'b0;
        end else begin
            if (w_skid_to_main)
                r_main_zero <= r_skid_zero;
            else if (w_new_to_main)
                r_main_zero <= (w_new_result == 32'd0);
            if (w_new_to_skid)
                r_skid_zero <= (w_new_result == 32'd0);
        end
    end

    assign out_zero = r_main_zero;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = r_main_valid;
    assign out_result = r_main_result;
    assign out_rd     = r_main_rd;
endmodule

// File: tb/tb_alu_shift_stage.sv
// Self-checking bench for alu_shift_stage: directed cases plus random traffic against a queue model.
`timescale 1ns/1ps

module tb_alu_shift_stage;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_op = 2'b00;
    logic [31:0]     in_src0 = '0;
    logic [31:0]     in_src1 = '0;
    logic [RD_W-1:0] in_rd = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_result;
    logic [RD_W-1:0] out_rd;
`ifdef SHIFT_ZERO_FLAG_EN
    logic            out_zero;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0]     res;
        logic [RD_W-1:0] rd;
    } entry_t;

    entry_t q[$];
    bit     rst_hold = 1'b0;

    always #5 clk = ~clk;

    alu_shift_stage #(.RD_W(RD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src0    (in_src0),
        .in_src1    (in_src1),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
`ifdef SHIFT_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    function automatic logic [31:0] ref_calc(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                             logic [RD_W-1:0] rd);
        int unsigned n = b % 32;
        logic [31:0] r;
        case (op)
            2'd0: r = a << n;
            2'd1: r = a >> n;
            2'd2: r = a[31] ? ~((~a) >> n) : (a >> n);
            default: r = a;
        endcase
        if (rd == 0) r = 32'd0;
        return r;
    endfunction

    function automatic logic exp_valid();
        return q.size() > 0;
    endfunction

    function automatic logic exp_ready();
        return (q.size() < 2) && !rst_hold;
    endfunction

    // Drive one cycle from a negedge, advance the model across the posedge, return at next negedge.
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [RD_W-1:0] rd,
                        input logic ordy, input logic fl, output logic acc);
        logic xf;
        entry_t e;
        in_valid  = v;
        in_op     = op;
        in_src0   = a;
        in_src1   = b;
        in_rd     = rd;
        out_ready = ordy;
        flush     = fl;
        acc = v && exp_ready() && !fl;
        xf  = exp_valid() && ordy;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (xf) void'(q.pop_front());
            if (acc) begin
                e.res = ref_calc(op, a, b, rd);
                e.rd  = rd;
                q.push_back(e);
            end
        end
        rst_hold = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic acc;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready, out_result, out_rd} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b r=%b res=%h rd=%h, want all 0",
                     out_valid, in_ready, out_result, out_rd);
        end
        rst_n = 1'b1;
        rst_hold = 1'b1;
        q.delete();
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_low: got %b want 0", in_ready);
        end
        step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1, 1'b0, acc);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic acc;
        logic [1:0]      ops [5] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd3};
        logic [31:0]     s0  [5] = '{32'h80000000, 32'h1, 32'h80000000, 32'h12345678, 32'h0};
        logic [31:0]     s1  [5] = '{32'd4, 32'h21, 32'd31, 32'd0, 32'd0};
        logic [RD_W-1:0] rds [5] = '{5'd3, 5'd1, 5'd2, 5'd0, 5'd5};
        logic [31:0]     want[5] = '{32'hF8000000, 32'h2, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ops[i], s0[i], s1[i], rds[i], 1'b1, 1'b0, acc);
            n_vec++;
            if (out_valid !== 1'b1 || out_result !== want[i] || out_rd !== rds[i]) begin
                n_err++;
                $display("FAIL directed_%0d: got v=%b res=%h rd=%0d want v=1 res=%h rd=%0d",
                         i, out_valid, out_result, out_rd, want[i], rds[i]);
            end
`ifdef SHIFT_ZERO_FLAG_EN
            n_vec++;
            if (out_zero !== (want[i] == 32'd0)) begin
                n_err++;
                $display("FAIL directed_zero_%0d: got %b want %b", i, out_zero, want[i] == 32'd0);
            end
`endif
        end
        step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [31:0] a_res, b_res, c_res;
        a_res = ref_calc(2'd0, 32'h0000_00F0, 32'd4, 5'd7);
        b_res = ref_calc(2'd1, 32'hF000_0000, 32'd8, 5'd8);
        c_res = ref_calc(2'd2, 32'h8000_0F00, 32'd36, 5'd9);
        step(1'b1, 2'd0, 32'h0000_00F0, 32'd4, 5'd7, 1'b0, 1'b0, acc);
        step(1'b1, 2'd1, 32'hF000_0000, 32'd8, 5'd8, 1'b0, 1'b0, acc);
        step(1'b1, 2'd2, 32'h8000_0F00, 32'd36, 5'd9, 1'b0, 1'b0, acc);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== a_res || acc !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_full: got ready=%b v=%b res=%h want 0/1/%h",
                     in_ready, out_valid, out_result, a_res);
        end
        step(1'b1, 2'd2, 32'h8000_0F00, 32'd36, 5'd9, 1'b1, 1'b0, acc);
        n_vec++;
        if (out_valid !== 1'b1 || out_result !== b_res || out_rd !== 5'd8) begin
            n_err++;
            $display("FAIL b2b_second: got v=%b res=%h rd=%0d want 1/%h/8",
                     out_valid, out_result, out_rd, b_res);
        end
        step(1'b1, 2'd2, 32'h8000_0F00, 32'd36, 5'd9, 1'b1, 1'b0, acc);
        n_vec++;
        if (acc !== 1'b1 || out_valid !== 1'b1 || out_result !== c_res || out_rd !== 5'd9) begin
            n_err++;
            $display("FAIL b2b_third: got v=%b res=%h rd=%0d want 1/%h/9",
                     out_valid, out_result, out_rd, c_res);
        end
        step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1, 1'b0, acc);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_drained: got v=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic acc;
        step(1'b1, 2'd3, 32'hAAAA_0001, 32'd0, 5'd11, 1'b0, 1'b0, acc);
        step(1'b1, 2'd3, 32'hAAAA_0002, 32'd0, 5'd12, 1'b0, 1'b0, acc);
        step(1'b1, 2'd3, 32'hAAAA_0003, 32'd0, 5'd13, 1'b1, 1'b1, acc);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_clear: got v=%b ready=%b want 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1, 1'b0, acc);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_ghost_%0d: got v=%b res=%h want v=0", i, out_valid, out_result);
            end
        end
    endtask

    task automatic test_random();
        logic acc;
        logic [1:0]      op;
        logic [31:0]     a, b;
        logic [RD_W-1:0] rd;
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b  = $urandom;
            rd = ($urandom_range(0, 7) == 0) ? '0 : RD_W'($urandom);
            step($urandom_range(0, 3) != 0, op, a, b, rd, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, acc);
            n_vec++;
            if (out_valid !== exp_valid() || in_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_hs_%0d: got v=%b ready=%b want %b/%b",
                         i, out_valid, in_ready, exp_valid(), exp_ready());
            end else if (exp_valid()) begin
                n_vec++;
                if (out_result !== q[0].res || out_rd !== q[0].rd) begin
                    n_err++;
                    $display("FAIL rand_data_%0d: got res=%h rd=%0d want res=%h rd=%0d",
                             i, out_result, out_rd, q[0].res, q[0].rd);
                end
`ifdef SHIFT_ZERO_FLAG_EN
                n_vec++;
                if (out_zero !== (q[0].res == 32'd0)) begin
                    n_err++;
                    $display("FAIL rand_zero_%0d: got %b want %b", i, out_zero, q[0].res == 32'd0);
                end
`endif
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic acc;
        step(1'b1, 2'd3, 32'h5555_0001, 32'd0, 5'd21, 1'b0, 1'b0, acc);
        step(1'b1, 2'd3, 32'h5555_0002, 32'd0, 5'd22, 1'b0, 1'b0, acc);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: got v=%b want 1", out_valid);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 32'd0 || out_rd !== '0) begin
            n_err++;
            $display("FAIL midrst_async: got v=%b ready=%b res=%h rd=%0d want all 0",
                     out_valid, in_ready, out_result, out_rd);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rst_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1, 1'b0, acc);
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_after_%0d: got v=%b ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
        step(1'b1, 2'd0, 32'h1, 32'd3, 5'd4, 1'b1, 1'b0, acc);
        n_vec++;
        if (out_valid !== 1'b1 || out_result !== 32'h8 || out_rd !== 5'd4) begin
            n_err++;
            $display("FAIL midrst_new: got v=%b res=%h rd=%0d want 1/8/4", out_valid, out_result, out_rd);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
